fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, meaning instruction word width.
REQ-002 The block SHALL provide parameter ADDR_W, default 10, meaning instruction memory index width; depth is 2^ADDR_W words.
REQ-003 The block SHALL provide parameter PC_STEP, default 1, meaning PC increment per sequential fetch.
REQ-004 The block SHALL provide parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-005 The block SHALL have port Clock_in, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port CS_Signal_reset, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-007 The block SHALL have port CS_Branch, input, 1 bit, meaning redirect the PC to PC_MUX_IN.
REQ-008 The block SHALL have port PC_MUX_IN, input, 32 bits, meaning branch/jump target PC.
REQ-009 The block SHALL have port CS_Stall, input, 1 bit, meaning downstream not ready; hold the fetch state.
REQ-010 The block SHALL have port CS_MEM_INS_WE, input, 1 bit, meaning instruction memory write enable.
REQ-011 The block SHALL have port MEM_WR_ADDR, input, ADDR_W bits, meaning instruction memory write index.
REQ-012 The block SHALL have port MEM_WR_DATA, input, DATA_W bits, meaning instruction memory write data.
REQ-013 The block SHALL have port MEM_INS_OUT, output, DATA_W bits, meaning fetched instruction (registered).
REQ-014 The block SHALL have port PC_INS, output, 32 bits, meaning PC of the instruction on MEM_INS_OUT.
REQ-015 The block SHALL have port PC_NEXT_INS, output, 32 bits, meaning PC_INS + PC_STEP, truncated to 32 bits.
REQ-016 The block SHALL have port INS_VALID, output, 1 bit, meaning MEM_INS_OUT/PC_INS hold a live instruction.
REQ-017 The block SHALL have port FETCH_COUNT, output, 32 bits, meaning number of valid fetches since reset.

Function
REQ-018 The block SHALL hold an internal 32-bit fetch PC; the memory read index SHALL be PC[ADDR_W-1:0] (upper bits ignored).
REQ-019 The memory read SHALL be synchronous with 1-cycle latency: the word at the PC before an edge appears on MEM_INS_OUT after it.
REQ-020 Edge priority SHALL be: CS_Branch, then CS_Stall, then normal advance.
REQ-021 Normal edge (no branch, no stall): MEM_INS_OUT <= mem[PC]; PC_INS <= PC; INS_VALID <= 1; PC <= PC + PC_STEP (mod 2^32); FETCH_COUNT += 1.
REQ-022 Stall edge (CS_Stall=1, CS_Branch=0): PC, MEM_INS_OUT, PC_INS, INS_VALID and FETCH_COUNT SHALL hold.
REQ-023 Branch edge (CS_Branch=1, with or without CS_Stall): PC <= PC_MUX_IN; INS_VALID <= 0; FETCH_COUNT holds; MEM_INS_OUT and PC_INS hold.
REQ-024 The branch penalty SHALL be exactly one bubble: the first normal edge after a branch presents mem[PC_MUX_IN] with INS_VALID=1.
REQ-025 Back-to-back branches SHALL each overwrite PC; only the last target is fetched; INS_VALID stays 0 throughout.
REQ-026 PC_NEXT_INS SHALL be combinational from PC_INS; PC wrap from 0xFFFFFFFF SHALL give 0x00000000 without error.
REQ-027 A write SHALL set mem[MEM_WR_ADDR] <= MEM_WR_DATA on the edge when CS_MEM_INS_WE=1, independent of stall/branch.
REQ-028 A same-edge read and write to the same index SHALL return the old word (read-first).
REQ-029 FETCH_COUNT SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 While CS_Signal_reset=1, immediately and without a clock edge: PC=RESET_PC, MEM_INS_OUT=0, PC_INS=0, INS_VALID=0, FETCH_COUNT=0; PC_NEXT_INS=PC_STEP.
REQ-031 Memory contents SHALL NOT be cleared by reset; writes are ignored while reset is asserted.
REQ-032 The first normal edge after reset release SHALL present mem[RESET_PC] with INS_VALID=1 and PC_INS=RESET_PC.
REQ-033 Reset asserted mid-stall or mid-branch SHALL override both; no pending branch target survives reset.

Verification
REQ-034 Defaults; preload mem[i]=0xA0000000+i for i=0..15; release reset; 4 normal edges -> MEM_INS_OUT 0xA0000000..0xA0000003, PC_INS 0..3, INS_VALID=1, FETCH_COUNT=4.
REQ-035 After 2 fetches assert CS_Stall for 3 edges -> outputs frozen at 0xA0000001/PC_INS=1, FETCH_COUNT=2; release -> next edge 0xA0000002.
REQ-036 CS_Branch=1, PC_MUX_IN=9 with CS_Stall=1 -> next edge INS_VALID=0; following normal edge MEM_INS_OUT=0xA0000009, PC_INS=9, PC_NEXT_INS=10.
REQ-037 PC_MUX_IN=0x00000405 (ADDR_W=10) -> fetched word is mem[5], PC_INS=0x405; PC_MUX_IN=0xFFFFFFFF -> after two fetches PC_INS=0x00000000.
REQ-038 Write mem[3]=0xDEADBEEF on the same edge as a fetch of index 3 -> old 0xA0000003 returned; a refetch returns 0xDEADBEEF.
REQ-039 Assert CS_Signal_reset asynchronously between edges mid-run -> outputs zero immediately, FETCH_COUNT=0; after release the first fetch is mem[0] with memory contents intact.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction memory with synchronous
// read-first port, branch redirect with a one-bubble penalty, and a fetch counter.
module fetch_unit #(
    parameter int unsigned   DATA_W   = 32,
    parameter int unsigned   ADDR_W   = 10,
    parameter int unsigned   PC_STEP  = 1,
    parameter logic [31:0]   RESET_PC = 32'h0000_0000
) (
    input  logic              Clock_in,
    input  logic              CS_Signal_reset,
    input  logic              CS_Branch,
    input  logic [31:0]       PC_MUX_IN,
    input  logic              CS_Stall,
    input  logic              CS_MEM_INS_WE,
    input  logic [ADDR_W-1:0] MEM_WR_ADDR,
    input  logic [DATA_W-1:0] MEM_WR_DATA,
    output logic [DATA_W-1:0] MEM_INS_OUT,
    output logic [31:0]       PC_INS,
    output logic [31:0]       PC_NEXT_INS,
    output logic              INS_VALID,
    output logic [31:0]       FETCH_COUNT
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [31:0] STEP  = 32'(PC_STEP);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       pc_reg;
    logic [DATA_W-1:0] ins_reg;
    logic [31:0]       pc_ins_reg;
    logic              valid_reg;
    logic [31:0]       count_reg;

    logic [ADDR_W-1:0] rd_idx;
    assign rd_idx = pc_reg[ADDR_W-1:0];

    // Memory has no reset branch, so its contents survive reset while writes
    // are blocked for as long as reset is held. The read uses the pre-edge
    // array value, giving read-first behaviour on a same-index write.
    always_ff @(posedge Clock_in or posedge CS_Signal_reset) begin
        if (CS_Signal_reset) begin
            pc_reg     <= RESET_PC;
            ins_reg    <= '0;
            pc_ins_reg <= '0;
            valid_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (CS_MEM_INS_WE) begin
                mem[MEM_WR_ADDR] <= MEM_WR_DATA;
            end
            if (CS_Branch) begin
                // Redirect only; the word in flight is dropped as the bubble.
                pc_reg    <= PC_MUX_IN;
                valid_reg <= 1'b0;
            end else if (!CS_Stall) begin
                ins_reg    <= mem[rd_idx];
                pc_ins_reg <= pc_reg;
                valid_reg  <= 1'b1;
                pc_reg     <= pc_reg + STEP;
                count_reg  <= count_reg + 32'd1;
            end
        end
    end

    assign MEM_INS_OUT = ins_reg;
    assign PC_INS      = pc_ins_reg;
    assign PC_NEXT_INS = pc_ins_reg + STEP;
    assign INS_VALID   = valid_reg;
    assign FETCH_COUNT = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a per-edge reference model pushes expected
// outputs into a queue that an independent monitor pops on each falling edge.
module tb_fetch_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              branch;
    logic [31:0]       target;
    logic              stall;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ins_out;
    logic [31:0]       pc_ins;
    logic [31:0]       pc_next;
    logic              ins_valid;
    logic [31:0]       fetch_count;

    fetch_unit dut (
        .Clock_in        (clk),
        .CS_Signal_reset (rst),
        .CS_Branch       (branch),
        .PC_MUX_IN       (target),
        .CS_Stall        (stall),
        .CS_MEM_INS_WE   (we),
        .MEM_WR_ADDR     (waddr),
        .MEM_WR_DATA     (wdata),
        .MEM_INS_OUT     (ins_out),
        .PC_INS          (pc_ins),
        .PC_NEXT_INS     (pc_next),
        .INS_VALID       (ins_valid),
        .FETCH_COUNT     (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pcins;
        logic [31:0] cnt;
        logic        valid;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_ins, m_pcins, m_cnt;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = 32'h0; m_pcins = 32'h0; m_cnt = 32'h0; m_valid = 1'b0;
    endtask

    // One clock edge: drive inputs, advance the model, queue the expectation.
    task automatic step(input logic b, input logic [31:0] t, input logic s,
                        input logic w, input logic [ADDR_W-1:0] wa, input logic [31:0] wd);
        exp_t e;
        branch = b; target = t; stall = s; we = w; waddr = wa; wdata = wd;
        if (b) begin
            m_pc = t;
            m_valid = 1'b0;
        end else if (!s) begin
            m_ins   = m_mem[m_pc % DEPTH];
            m_pcins = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 1;
            m_cnt   = m_cnt + 1;
        end
        if (w) m_mem[wa] = wd;
        e.ins = m_ins; e.pcins = m_pcins; e.cnt = m_cnt; e.valid = m_valid;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic fetch();
        step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    endtask

    // Monitor: independent of stimulus, compares whatever the DUT shows.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (ins_out === e.ins && pc_ins === e.pcins && pc_next === e.pcins + 32'd1 &&
                    ins_valid === e.valid && fetch_count === e.cnt)
                    n_pass++;
                else
                    $display("FAIL edge: got ins=%08h pc=%08h nxt=%08h v=%b cnt=%0d expected ins=%08h pc=%08h nxt=%08h v=%b cnt=%0d",
                             ins_out, pc_ins, pc_next, ins_valid, fetch_count,
                             e.ins, e.pcins, e.pcins + 32'd1, e.valid, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1; branch = 1'b0; target = '0; stall = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        model_reset();
        #1;
        check("reset_ins", ins_out, 32'h0);
        check("reset_pc_ins", pc_ins, 32'h0);
        check("reset_pc_next", pc_next, 32'h1);
        check("reset_valid", {31'h0, ins_valid}, 32'h0);
        check("reset_count", fetch_count, 32'h0);

        // Writes under reset must be ignored; the preload below overwrites anyway.
        we = 1'b1; waddr = '0; wdata = 32'h5555_5555;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        we = 1'b0; stall = 1'b1;
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 32'h0, 1'b1, 1'b1, ADDR_W'(i), 32'hA000_0000 + 32'(i));

        repeat (4) fetch();
        check("seq_ins", ins_out, 32'hA000_0003);
        check("seq_pc_ins", pc_ins, 32'd3);
        check("seq_count", fetch_count, 32'd4);

        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0);
        check("stall_ins", ins_out, 32'hA000_0003);
        check("stall_count", fetch_count, 32'd4);
        fetch();
        check("unstall_ins", ins_out, 32'hA000_0004);

        step(1'b1, 32'd9, 1'b1, 1'b0, '0, 32'h0);
        check("branch_bubble", {31'h0, ins_valid}, 32'h0);
        fetch();
        check("branch_ins", ins_out, 32'hA000_0009);
        check("branch_pc_next", pc_next, 32'd10);

        step(1'b1, 32'h0000_0405, 1'b0, 1'b0, '0, 32'h0);
        fetch();
        check("alias_ins", ins_out, 32'hA000_0005);
        check("alias_pc_ins", pc_ins, 32'h0000_0405);

        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 32'h0);
        fetch();
        check("wrap_pc_next", pc_next, 32'h0);
        fetch();
        check("wrap_pc_ins", pc_ins, 32'h0);

        step(1'b1, 32'd20, 1'b0, 1'b0, '0, 32'h0);
        step(1'b1, 32'd30, 1'b1, 1'b0, '0, 32'h0);
        fetch();
        check("b2b_pc_ins", pc_ins, 32'd30);

        step(1'b1, 32'd3, 1'b0, 1'b0, '0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, ADDR_W'(3), 32'hDEAD_BEEF);
        check("read_first_old", ins_out, 32'hA000_0003);
        step(1'b1, 32'd3, 1'b0, 1'b0, '0, 32'h0);
        fetch();
        check("read_first_new", ins_out, 32'hDEAD_BEEF);

        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, ADDR_W'($urandom), $urandom);

        // Asynchronous reset between edges, with a branch pending and a write attempted.
        branch = 1'b1; target = 32'd77; stall = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_ins", ins_out, 32'h0);
        check("async_valid", {31'h0, ins_valid}, 32'h0);
        check("async_count", fetch_count, 32'h0);
        we = 1'b1; waddr = '0; wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        we = 1'b0; branch = 1'b0; stall = 1'b0;
        rst = 1'b0;
        fetch();
        check("post_reset_ins", ins_out, m_mem[0]);
        check("post_reset_pc_ins", pc_ins, 32'h0);
        check("post_reset_count", fetch_count, 32'd1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
